apb_uart_slave: RTL and testbench

- APB slave front end that sits directly downstream of the UART receive block and consumes its outputs: rx_data, data_ready, overrun_error and framing_error.
- Drives the receiver's configuration inputs, data_size and bit_period, from software-writable registers.
- Issues the data_read pulse that clears the receive buffer.
- The bus is 8-bit, zero-wait-state APB (no pready port).

---
 rtl/apb_uart_slave.sv | 115 +++++++++++
 tb/tb_apb_uart_slave.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_uart_slave.sv
// APB register front end for the UART receiver.
// Exposes status/error/data and drives bit_period / data_size.
module apb_uart_slave #(
  parameter logic [13:0] BP_RESET = 14'd10,
  parameter logic [3:0]  DS_RESET = 4'd8
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [2:0]  paddr,
  input  logic [7:0]  pwdata,
  output logic [7:0]  prdata,
  output logic        pslverr,
  input  logic [7:0]  rx_data,
  input  logic        data_ready,
  input  logic        overrun_error,
  input  logic        framing_error,
  output logic        data_read,
  output logic [3:0]  data_size,
  output logic [13:0] bit_period
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    ERR
  } state_t;

  state_t      state;
  state_t      dec;
  logic [2:0]  addr_q;
  logic [7:0]  rx_q;
  logic        dr_q;
  logic        oe_q;
  logic        fe_q;
  logic [7:0]  rx_mask;
  logic [7:0]  sel;

  always_comb begin
    dec = ERR;
    if (pwrite) begin
      if (paddr inside {3'd2, 3'd3, 3'd4}) dec = WRITE;
    end else begin
      if (!(paddr inside {3'd5, 3'd7})) dec = READ;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      rx_q       <= '0;
      dr_q       <= 1'b0;
      oe_q       <= 1'b0;
      fe_q       <= 1'b0;
      bit_period <= BP_RESET;
      data_size  <= DS_RESET;
    end else begin
      // shadows freeze during READ so data matches the setup edge
      if (state != READ) begin
        rx_q <= rx_data;
        dr_q <= data_ready;
        oe_q <= overrun_error;
        fe_q <= framing_error;
      end
      unique case (state)
        IDLE: begin
          if (psel && !penable) begin
            addr_q <= paddr;
            state  <= dec;
          end
        end
        WRITE: begin
          case (addr_q)
            3'd2:    bit_period[7:0]  <= pwdata;
            3'd3:    bit_period[13:8] <= pwdata[5:0];
            3'd4:    data_size        <= pwdata[3:0];
            default: ;
          endcase
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    case (data_size)
      4'd5:    rx_mask = {3'b0, rx_q[4:0]};
      4'd6:    rx_mask = {2'b0, rx_q[5:0]};
      4'd7:    rx_mask = {1'b0, rx_q[6:0]};
      default: rx_mask = rx_q;
    endcase
  end

  always_comb begin
    case (addr_q)
      3'd0:    sel = {7'b0, dr_q};
      3'd1:    sel = {6'b0, oe_q, fe_q};
      3'd2:    sel = bit_period[7:0];
      3'd3:    sel = {2'b0, bit_period[13:8]};
      3'd4:    sel = {4'b0, data_size};
      3'd6:    sel = rx_mask;
      default: sel = 8'h00;
    endcase
  end

  assign prdata    = (state == READ) ? sel : 8'h00;
  assign pslverr   = (state == ERR);
  assign data_read = (state == READ) && (addr_q == 3'd6);

endmodule

// File: tb/tb_apb_uart_slave.sv
// Bench for apb_uart_slave: directed register steps plus
// randomized transfers against an arithmetic register model.
module tb_apb_uart_slave;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [2:0]  paddr = '0;
  logic [7:0]  pwdata = '0;
  logic [7:0]  prdata;
  logic        pslverr;
  logic [7:0]  rx_data = '0;
  logic        data_ready = 1'b0;
  logic        overrun_error = 1'b0;
  logic        framing_error = 1'b0;
  logic        data_read;
  logic [3:0]  data_size;
  logic [13:0] bit_period;

  int tests = 0;
  int fails = 0;
  int m_bp = 10;
  int m_ds = 8;

  apb_uart_slave dut (
    .clk(clk), .n_rst(n_rst),
    .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata),
    .pslverr(pslverr), .rx_data(rx_data),
    .data_ready(data_ready),
    .overrun_error(overrun_error),
    .framing_error(framing_error),
    .data_read(data_read),
    .data_size(data_size),
    .bit_period(bit_period)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // one transfer; results sampled mid access cycle
  task automatic xfer(input logic w, input int a,
                      input int d, output int rd,
                      output int err, output int drd);
    @(negedge clk);
    psel = 1'b1;
    penable = 1'b0;
    pwrite = w;
    paddr = 3'(a);
    pwdata = 8'(d);
    @(negedge clk);
    penable = 1'b1;
    #1;
    rd = int'(prdata);
    err = int'(pslverr);
    drd = int'(data_read);
  endtask

  task automatic idle();
    @(negedge clk);
    psel = 1'b0;
    penable = 1'b0;
    #1;
  endtask

  function automatic int model_read(int a);
    int r;
    case (a)
      0: r = int'(data_ready);
      1: r = 2 * int'(overrun_error) + int'(framing_error);
      2: r = m_bp % 256;
      3: r = m_bp / 256;
      4: r = m_ds;
      6: begin
        r = int'(rx_data);
        if (m_ds >= 5 && m_ds <= 7) r = r % (1 << m_ds);
      end
      default: r = 0;
    endcase
    return r;
  endfunction

  function automatic bit model_err(logic w, int a);
    if (w) return !(a >= 2 && a <= 4);
    return (a == 5 || a == 7);
  endfunction

  function automatic void model_write(int a, int d);
    case (a)
      2: m_bp = (m_bp / 256) * 256 + d;
      3: m_bp = (d % 64) * 256 + m_bp % 256;
      4: m_ds = d % 16;
      default: ;
    endcase
  endfunction

  initial begin
    int rd, err, drd;
    int a, d;
    logic w;

    #12;
    check("rst_prdata", 32'(prdata), 0);
    check("rst_pslverr", 32'(pslverr), 0);
    check("rst_data_read", 32'(data_read), 0);
    check("rst_bp", 32'(bit_period), 10);
    check("rst_ds", 32'(data_size), 8);
    @(negedge clk);
    n_rst = 1'b1;

    xfer(1'b0, 2, 0, rd, err, drd);
    check("rd_bp_lo", rd, 32'h0A);
    check("rd_bp_lo_err", err, 0);
    xfer(1'b0, 3, 0, rd, err, drd);
    check("rd_bp_hi", rd, 32'h00);
    xfer(1'b0, 4, 0, rd, err, drd);
    check("rd_ds", rd, 32'h08);
    check("rd_ds_err", err, 0);
    idle();

    xfer(1'b1, 2, 'hA0, rd, err, drd);
    check("wr_prdata_zero", rd, 0);
    xfer(1'b1, 3, 'hFF, rd, err, drd);
    xfer(1'b1, 4, 'h05, rd, err, drd);
    check("wr_ds_err", err, 0);
    idle();
    model_write(2, 'hA0);
    model_write(3, 'hFF);
    model_write(4, 'h05);
    check("bp_after_wr", 32'(bit_period), 32'h3FA0);
    check("ds_after_wr", 32'(data_size), 5);
    xfer(1'b0, 3, 0, rd, err, drd);
    check("rd_bp_hi_3f", rd, 32'h3F);
    idle();

    rx_data = 8'hD5;
    data_ready = 1'b1;
    xfer(1'b0, 0, 0, rd, err, drd);
    check("rd_status", rd, 1);
    check("status_no_dread", drd, 0);
    xfer(1'b0, 6, 0, rd, err, drd);
    check("rd_rxdata_ds5", rd, 32'h15);
    check("rxdata_dread", drd, 1);
    idle();
    check("dread_one_cycle", 32'(data_read), 0);

    framing_error = 1'b1;
    overrun_error = 1'b1;
    xfer(1'b0, 1, 0, rd, err, drd);
    check("rd_error", rd, 3);
    xfer(1'b1, 1, 'h77, rd, err, drd);
    check("wr_ro1_err", err, 1);
    check("wr_ro1_prdata", rd, 0);
    xfer(1'b1, 6, 'h77, rd, err, drd);
    check("wr_ro6_err", err, 1);
    check("wr_ro6_dread", drd, 0);
    xfer(1'b0, 5, 0, rd, err, drd);
    check("rd_rsv5_err", err, 1);
    check("rd_rsv5_prdata", rd, 0);
    idle();
    check("err_clears", 32'(pslverr), 0);
    check("err_bp_keep", 32'(bit_period), 32'h3FA0);
    check("err_ds_keep", 32'(data_size), 5);

    xfer(1'b1, 4, 'h07, rd, err, drd);
    model_write(4, 'h07);
    xfer(1'b0, 4, 0, rd, err, drd);
    check("b2b_rd_ds", rd, 7);
    idle();

    @(negedge clk);
    psel = 1'b1;
    penable = 1'b0;
    pwrite = 1'b1;
    paddr = 3'd2;
    pwdata = 8'h55;
    @(negedge clk);
    penable = 1'b1;
    #1;
    n_rst = 1'b0;
    #2;
    check("rst_mid_pslverr", 32'(pslverr), 0);
    check("rst_mid_bp", 32'(bit_period), 10);
    @(negedge clk);
    psel = 1'b0;
    penable = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    m_bp = 10;
    m_ds = 8;
    @(negedge clk);
    check("rst_abandon_bp", 32'(bit_period), 10);
    check("rst_abandon_ds", 32'(data_size), 8);
    xfer(1'b0, 2, 0, rd, err, drd);
    check("post_rst_rd", rd, 32'h0A);
    idle();

    for (int i = 0; i < 60; i++) begin
      int erd, eerr, edr;
      rx_data = 8'($urandom);
      data_ready = 1'($urandom);
      overrun_error = 1'($urandom);
      framing_error = 1'($urandom);
      a = int'($urandom_range(0, 7));
      w = 1'($urandom);
      d = int'($urandom_range(0, 255));
      eerr = int'(model_err(w, a));
      erd = (w || eerr != 0) ? 0 : model_read(a);
      edr = (!w && a == 6) ? 1 : 0;
      xfer(w, a, d, rd, err, drd);
      check("rnd_prdata", rd, erd);
      check("rnd_pslverr", err, eerr);
      check("rnd_dread", drd, edr);
      if (w && eerr == 0) model_write(a, d);
      idle();
      check("rnd_bp", 32'(bit_period), m_bp);
      check("rnd_ds", 32'(data_size), m_ds);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
